// File: rtl/afg_pkg.sv
// Shared types and default widths for the arbitrary function generator
// address path.
package afg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W_DEF = 10;
    localparam int CNT_W_DEF  = 16;

    // A burst length of zero selects gate-controlled continuous running.
    localparam int BURST_CONTINUOUS = 0;

endpackage

// File: rtl/burst_addr_gen_if.sv
// Control/status bundle between the gating logic and the waveform address
// generator.
interface burst_addr_gen_if
    import afg_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic              Gate_in;
    logic              Trig;
    logic              Abort;
    logic [ACC_W-1:0]  FTW;
    logic [CNT_W-1:0]  Burst_len;
    logic [ADDR_W-1:0] Addr_out;
    logic              BA_Carry_out;
    logic              Active;
    logic              Burst_done;

    modport master (
        output Gate_in, Trig, Abort, FTW, Burst_len,
        input  Addr_out, BA_Carry_out, Active, Burst_done
    );

    modport slave (
        input  Gate_in, Trig, Abort, FTW, Burst_len,
        output Addr_out, BA_Carry_out, Active, Burst_done
    );

endinterface

// File: rtl/phase_accum.sv
// Phase accumulator with a registered carry flag that marks each period
// wrap.
module phase_accum
    import afg_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] FTW,
    output logic [ACC_W-1:0] acc,
    output logic             wrap
);

    logic [ACC_W-1:0] acc_q;
    logic             wrap_q;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, FTW};

    // A clear still lets the carry through so a period-ending wrap is
    // reported on the same edge that zeroes the phase.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= en & sum[ACC_W];
            if (clr) begin
                acc_q <= '0;
            end else if (en) begin
                acc_q <= sum[ACC_W-1:0];
            end
        end
    end

    assign acc  = acc_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/burst_addr_gen.sv
// Waveform RAM address generator: runs the phase accumulator while gated or
// for a fixed number of periods after a trigger.
module burst_addr_gen
    import afg_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    burst_addr_gen_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;

    logic             accClr;
    logic             accEn;
    logic [ACC_W-1:0] acc;
    logic             wrap;
    logic [ACC_W:0]   sumPeek;
    logic             wrapNow;
    logic             burstMode;
    logic             lastPeriod;

    phase_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (accClr),
        .en    (accEn),
        .FTW   (bus.FTW),
        .acc   (acc),
        .wrap  (wrap)
    );

    // Look ahead at the carry the accumulator is about to register.
    assign sumPeek    = {1'b0, acc} + {1'b0, bus.FTW};
    assign wrapNow    = sumPeek[ACC_W];
    assign burstMode  = (len_q != CNT_W'(BURST_CONTINUOUS));
    assign lastPeriod = (cnt_q == (len_q - CNT_W'(1)));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        accClr  = 1'b0;
        accEn   = 1'b0;

        if (bus.Abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            accClr  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    accClr = 1'b1;
                    if (bus.Trig || bus.Gate_in) begin
                        state_d = RUN;
                        len_d   = bus.Burst_len;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    accEn = 1'b1;
                    // Stopping is only ever decided on a wrap edge, so a
                    // period is never cut short by the gate.
                    if (wrapNow) begin
                        if (!burstMode) begin
                            if (!bus.Gate_in) begin
                                state_d = IDLE;
                                accClr  = 1'b1;
                            end
                        end else if (lastPeriod) begin
                            state_d = IDLE;
                            accClr  = 1'b1;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    accClr  = 1'b1;
                end
            endcase
        end
    end

    assign bus.Addr_out     = acc[ACC_W-1 -: ADDR_W];
    assign bus.BA_Carry_out = wrap;
    assign bus.Active       = (state_q == RUN);
    assign bus.Burst_done   = done_q;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Self-checking bench for burst_addr_gen: directed scenarios followed by
// random stimulus, all checked against a period-counting reference model.
module tb_burst_addr_gen;

    localparam int ACC_W  = 8;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    burst_addr_gen_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    burst_addr_gen #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int testCount = 0;
    int failCount = 0;
    int obsCarries = 0;
    int obsDones = 0;

    // Reference model: phase as a plain integer, periods counted upward.
    bit mRun;
    int mPhase;
    int mPeriods;
    int mLen;
    bit mCarry;
    bit mDone;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mPhase = 0; mPeriods = 0; mLen = 0; mCarry = 0; mDone = 0;
    endtask

    task automatic modelStep(input bit gate, input bit trig, input bit abort,
                             input int ftw, input int blen);
        int total;
        mCarry = 0;
        mDone  = 0;
        if (abort) begin
            mRun = 0; mPhase = 0; mPeriods = 0;
        end else if (!mRun) begin
            mPhase = 0;
            if (trig || gate) begin
                mRun = 1; mLen = blen % 16; mPeriods = 0;
            end
        end else begin
            total  = mPhase + (ftw % 256);
            mCarry = (total >= 256);
            mPhase = total % 256;
            if (mCarry) begin
                if (mLen == 0) begin
                    if (!gate) begin
                        mRun = 0; mPhase = 0;
                    end
                end else begin
                    mPeriods++;
                    if (mPeriods == mLen) begin
                        mRun = 0; mPhase = 0; mDone = 1; mPeriods = 0;
                    end
                end
            end
        end
    endtask

    // One clock of stimulus, then all four outputs compared just after the edge.
    task automatic applyStimulus(input bit gate, input bit trig, input bit abort,
                                 input int ftw, input int blen);
        bus.Gate_in   = gate;
        bus.Trig      = trig;
        bus.Abort     = abort;
        bus.FTW       = 8'(ftw);
        bus.Burst_len = 4'(blen);
        @(posedge Clock);
        modelStep(gate, trig, abort, ftw, blen);
        #1;
        checkOutput("addr",   int'(bus.Addr_out),     mPhase / 16);
        checkOutput("carry",  int'(bus.BA_Carry_out), int'(mCarry));
        checkOutput("active", int'(bus.Active),       int'(mRun));
        checkOutput("done",   int'(bus.Burst_done),   int'(mDone));
        obsCarries += int'(bus.BA_Carry_out);
        obsDones   += int'(bus.Burst_done);
    endtask

    initial begin
        bit dropped;
        int guard;
        bit gate, trig, abort;
        int ftw, blen;

        bus.Gate_in = 1'b1; bus.Trig = 1'b0; bus.Abort = 1'b0;
        bus.FTW = 8'h40; bus.Burst_len = '0;
        modelReset();

        // Reset held with the gate high.
        repeat (3) @(posedge Clock);
        #1;
        checkOutput("rstAddr",   int'(bus.Addr_out),     0);
        checkOutput("rstActive", int'(bus.Active),       0);
        checkOutput("rstCarry",  int'(bus.BA_Carry_out), 0);
        checkOutput("rstDone",   int'(bus.Burst_done),   0);
        Reset = 1'b0;

        // Continuous run, FTW=0x40: 0,4,8,C,0,...
        repeat (10) applyStimulus(1, 0, 0, 'h40, 0);
        repeat (2) applyStimulus(0, 0, 1, 0, 0);

        // Gate drops mid-period: the period completes, then exactly one carry.
        obsCarries = 0;
        dropped = 0;
        for (int i = 0; i < 20; i++) begin
            if (mRun && (mPhase / 16) == 6) dropped = 1;
            applyStimulus(!dropped, 0, 0, 'h30, 0);
        end
        checkOutput("contCarries", obsCarries, 1);
        checkOutput("contIdle", int'(bus.Active), 0);

        // Three-period burst with a stray trigger and a length change mid-run.
        obsCarries = 0; obsDones = 0;
        applyStimulus(0, 1, 0, 'h80, 3);
        for (int i = 0; i < 12; i++) applyStimulus(0, i == 3, 0, 'h80, (i < 2) ? 3 : 7);
        checkOutput("burstCarries", obsCarries, 3);
        checkOutput("burstDones", obsDones, 1);
        checkOutput("burstIdle", int'(bus.Active), 0);

        // Abort on the very edge that would wrap from 0xC0.
        guard = 0;
        while (!(mRun && mPhase == 'hC0) && guard < 10) begin
            applyStimulus(1, 0, 0, 'h40, 0);
            guard++;
        end
        checkOutput("abortSetup", mPhase, 'hC0);
        applyStimulus(0, 0, 1, 'h40, 0);
        checkOutput("abortAddr",   int'(bus.Addr_out),     0);
        checkOutput("abortCarry",  int'(bus.BA_Carry_out), 0);
        checkOutput("abortActive", int'(bus.Active),       0);

        // FTW of zero stalls in RUN until aborted.
        applyStimulus(1, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 0, 0, 0, 0);
        checkOutput("stallActive", int'(bus.Active), 1);
        checkOutput("stallAddr", int'(bus.Addr_out), 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("stallAbort", int'(bus.Active), 0);

        // Asynchronous reset between edges in the middle of a burst.
        applyStimulus(0, 1, 0, 'h80, 5);
        repeat (4) applyStimulus(0, 0, 0, 'h80, 5);
        #3;
        Reset = 1'b1;
        #1;
        checkOutput("asyncActive", int'(bus.Active),       0);
        checkOutput("asyncAddr",   int'(bus.Addr_out),     0);
        checkOutput("asyncCarry",  int'(bus.BA_Carry_out), 0);
        checkOutput("asyncDone",   int'(bus.Burst_done),   0);
        modelReset();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        obsCarries = 0; obsDones = 0;
        applyStimulus(0, 1, 0, 'h80, 5);
        repeat (14) applyStimulus(0, 0, 0, 'h80, 5);
        checkOutput("restartCarries", obsCarries, 5);
        checkOutput("restartDones", obsDones, 1);

        // Random traffic against the model.
        gate = 0; ftw = 'h40; blen = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) gate = !gate;
            if ($urandom_range(0, 7) == 0) ftw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(16, 255);
            if ($urandom_range(0, 11) == 0) blen = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 5);
            trig  = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 49) == 0);
            applyStimulus(gate, trig, abort, ftw, blen);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
